// File: rtl/reg_cmd_ctrl.sv
// rtl/reg_cmd_ctrl.sv - UART byte-frame parser driving register-file writes/reads and returning read data to UART TX
// Frames: WR_CMD,addr,data or RD_CMD,addr; bad address or inter-byte timeout pulses Frame_Err.
module reg_cmd_ctrl #(
   parameter int                    DATA_WIDTH = 8,
   parameter int                    ADDR_WIDTH = 4,
   parameter logic [DATA_WIDTH-1:0] WR_CMD     = 8'hAA,
   parameter logic [DATA_WIDTH-1:0] RD_CMD     = 8'hBB,
   parameter int                    TIMEOUT    = 1023
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] RX_P_DATA,
   input  logic                  RX_D_VLD,
   output logic                  WR_En,
   output logic                  RD_EN,
   output logic [ADDR_WIDTH-1:0] Address,
   output logic [DATA_WIDTH-1:0] WrData,
   input  logic [DATA_WIDTH-1:0] RdData,
   input  logic                  RdData_Vaild,
   output logic [DATA_WIDTH-1:0] TX_P_DATA,
   output logic                  TX_D_VLD,
   input  logic                  TX_Busy,
   output logic                  Frame_Err,
   output logic                  Ctrl_Busy
);

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      IDLE, WR_ADDR, WR_DATA, WRITE, RD_ADDR, READ, RD_WAIT, SEND
   } state_t;

   state_t                  state, next_state;
   logic [DATA_WIDTH-1:0]   addr_q, addr_q_n;
   logic [CW-1:0]           cnt, cnt_n;
   logic                    timed, timeout_hit, addr_q_ok, rx_addr_ok;
   logic                    wr_en_n, rd_en_n, tx_vld_n, err_n, busy_n;
   logic [ADDR_WIDTH-1:0]   address_n;
   logic [DATA_WIDTH-1:0]   wrdata_n, tx_data_n;

   assign addr_q_ok  = (addr_q[DATA_WIDTH-1:ADDR_WIDTH] == '0);
   assign rx_addr_ok = (RX_P_DATA[DATA_WIDTH-1:ADDR_WIDTH] == '0);
   assign timed      = (state == WR_ADDR) || (state == WR_DATA) || (state == RD_ADDR);
   // Counter holds the idle cycles already spent, so the TIMEOUT-th idle edge fires.
   assign timeout_hit = timed && !RX_D_VLD && (cnt == CW'(TIMEOUT - 1));

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state     <= IDLE;
         addr_q    <= '0;
         cnt       <= '0;
         WR_En     <= 1'b0;
         RD_EN     <= 1'b0;
         Address   <= '0;
         WrData    <= '0;
         TX_P_DATA <= '0;
         TX_D_VLD  <= 1'b0;
         Frame_Err <= 1'b0;
         Ctrl_Busy <= 1'b0;
      end else begin
         state     <= next_state;
         addr_q    <= addr_q_n;
         cnt       <= cnt_n;
         WR_En     <= wr_en_n;
         RD_EN     <= rd_en_n;
         Address   <= address_n;
         WrData    <= wrdata_n;
         TX_P_DATA <= tx_data_n;
         TX_D_VLD  <= tx_vld_n;
         Frame_Err <= err_n;
         Ctrl_Busy <= busy_n;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (RX_D_VLD && RX_P_DATA == WR_CMD)      next_state = WR_ADDR;
            else if (RX_D_VLD && RX_P_DATA == RD_CMD) next_state = RD_ADDR;
         end
         WR_ADDR: begin
            if (RX_D_VLD)         next_state = WR_DATA;
            else if (timeout_hit) next_state = IDLE;
         end
         WR_DATA: begin
            if (RX_D_VLD)         next_state = addr_q_ok ? WRITE : IDLE;
            else if (timeout_hit) next_state = IDLE;
         end
         WRITE:   next_state = IDLE;
         RD_ADDR: begin
            if (RX_D_VLD)         next_state = rx_addr_ok ? READ : IDLE;
            else if (timeout_hit) next_state = IDLE;
         end
         READ:    next_state = RD_WAIT;
         RD_WAIT: if (RdData_Vaild) next_state = SEND;
         SEND:    if (!TX_Busy) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      wr_en_n   = (next_state == WRITE);
      rd_en_n   = (next_state == READ);
      tx_vld_n  = (state == SEND) && !TX_Busy;
      busy_n    = (next_state != IDLE);
      err_n     = timeout_hit ||
                  (RX_D_VLD && (((state == WR_DATA) && !addr_q_ok) ||
                                ((state == RD_ADDR) && !rx_addr_ok)));
      cnt_n     = (timed && (next_state == state) && !RX_D_VLD) ? cnt + 1'b1 : '0;
      addr_q_n  = (state == WR_ADDR && RX_D_VLD) ? RX_P_DATA : addr_q;
      address_n = Address;
      wrdata_n  = WrData;
      tx_data_n = TX_P_DATA;
      if (state == WR_DATA && next_state == WRITE) begin
         address_n = addr_q[ADDR_WIDTH-1:0];
         wrdata_n  = RX_P_DATA;
      end
      if (state == RD_ADDR && next_state == READ)
         address_n = RX_P_DATA[ADDR_WIDTH-1:0];
      if (state == RD_WAIT && RdData_Vaild)
         tx_data_n = RdData;
   end

endmodule

// File: tb/tb_reg_cmd_ctrl.sv
// tb/tb_reg_cmd_ctrl.sv - self-checking bench for reg_cmd_ctrl
// Table vectors, hand-written corner sequences and random frames against a frame-level model.
module tb_reg_cmd_ctrl;

   logic       CLK = 1'b0;
   logic       RST;
   logic [7:0] RX_P_DATA;
   logic       RX_D_VLD;
   logic       WR_En, RD_EN;
   logic [3:0] Address;
   logic [7:0] WrData;
   logic [7:0] RdData = 8'h00;
   logic       RdData_Vaild = 1'b0;
   logic [7:0] TX_P_DATA;
   logic       TX_D_VLD;
   logic       TX_Busy;
   logic       Frame_Err, Ctrl_Busy;

   reg_cmd_ctrl dut (
      .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
      .WR_En(WR_En), .RD_EN(RD_EN), .Address(Address), .WrData(WrData),
      .RdData(RdData), .RdData_Vaild(RdData_Vaild), .TX_P_DATA(TX_P_DATA),
      .TX_D_VLD(TX_D_VLD), .TX_Busy(TX_Busy), .Frame_Err(Frame_Err), .Ctrl_Busy(Ctrl_Busy)
   );

   always #5 CLK = ~CLK;

   // Register-file stand-in: read data valid one cycle after RD_EN.
   logic [7:0] rf_mem [16] = '{default: 8'h00};
   always @(posedge CLK) begin
      if (WR_En) rf_mem[Address] <= WrData;
      RdData_Vaild <= RD_EN;
      if (RD_EN) RdData <= rf_mem[Address];
   end

   int n_wr = 0, n_rd = 0, n_err = 0, n_tx = 0, n_both = 0;
   logic [3:0] last_wr_addr = '0;
   logic [7:0] last_wr_data = '0, last_tx = '0;
   always @(negedge CLK) begin
      if (WR_En) begin n_wr++; last_wr_addr = Address; last_wr_data = WrData; end
      if (RD_EN) n_rd++;
      if (Frame_Err) n_err++;
      if (TX_D_VLD) begin n_tx++; last_tx = TX_P_DATA; end
      if (WR_En && RD_EN) n_both++;
   end

   int checks = 0, errors = 0;
   int b_wr, b_rd, b_err, b_tx;
   logic [7:0] ref_mem [16];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic snap();
      b_wr = n_wr; b_rd = n_rd; b_err = n_err; b_tx = n_tx;
   endtask

   // Called at a negedge; returns at a negedge.
   task automatic send_byte(input logic [7:0] b, input int gap);
      RX_P_DATA = b;
      RX_D_VLD  = 1'b1;
      @(negedge CLK);
      RX_D_VLD  = 1'b0;
      repeat (gap) @(negedge CLK);
   endtask

   task automatic check_frame(input string tag, input int ew, input int er, input int ee,
                              input int et, input logic [3:0] ea, input logic [7:0] ev);
      chk({tag, "_wr"},  n_wr - b_wr,   ew);
      chk({tag, "_rd"},  n_rd - b_rd,   er);
      chk({tag, "_err"}, n_err - b_err, ee);
      chk({tag, "_tx"},  n_tx - b_tx,   et);
      if (ew != 0) begin
         chk({tag, "_waddr"}, last_wr_addr, ea);
         chk({tag, "_wdata"}, last_wr_data, ev);
      end
      if (et != 0) chk({tag, "_txdata"}, last_tx, ev);
   endtask

   // Frame-level model: nb is how many of the frame's bytes were actually sent.
   task automatic predict(input logic [7:0] op, input logic [7:0] a, input logic [7:0] d,
                          input int nb, output int ew, output int er, output int ee,
                          output int et, output logic [7:0] ev);
      logic legal;
      legal = (a < 8'd16);
      ew = 0; er = 0; ee = 0; et = 0; ev = 8'h00;
      if (op == 8'hAA) begin
         if (nb < 3 || !legal) ee = 1;
         else begin ew = 1; ref_mem[a[3:0]] = d; ev = d; end
      end else if (op == 8'hBB) begin
         if (nb < 2 || !legal) ee = 1;
         else begin er = 1; et = 1; ev = ref_mem[a[3:0]]; end
      end
   endtask

   typedef struct {
      logic [7:0] b0, b1, b2;
      int         nb;
      int         e_wr, e_rd, e_err, e_tx;
      logic [3:0] e_addr;
      logic [7:0] e_val;
   } vec_t;

   vec_t vecs [12];

   initial begin
      int ew, er, ee, et, seen, changes, pulses;
      logic [7:0] ev, hold;

      vecs[0]  = '{8'hAA, 8'h03, 8'h5C, 3, 1, 0, 0, 0, 4'h3, 8'h5C};
      vecs[1]  = '{8'hBB, 8'h03, 8'h00, 2, 0, 1, 0, 1, 4'h3, 8'h5C};
      vecs[2]  = '{8'hAA, 8'h13, 8'h77, 3, 0, 0, 1, 0, 4'h0, 8'h00};
      vecs[3]  = '{8'hBB, 8'hF0, 8'h00, 2, 0, 0, 1, 0, 4'h0, 8'h00};
      vecs[4]  = '{8'h12, 8'h00, 8'h00, 1, 0, 0, 0, 0, 4'h0, 8'h00};
      vecs[5]  = '{8'hAA, 8'h0F, 8'hFF, 3, 1, 0, 0, 0, 4'hF, 8'hFF};
      vecs[6]  = '{8'hBB, 8'h0F, 8'h00, 2, 0, 1, 0, 1, 4'hF, 8'hFF};
      vecs[7]  = '{8'hBB, 8'h07, 8'h00, 2, 0, 1, 0, 1, 4'h7, 8'h00};
      vecs[8]  = '{8'hAA, 8'h10, 8'h11, 3, 0, 0, 1, 0, 4'h0, 8'h00};
      vecs[9]  = '{8'hAA, 8'h00, 8'hA5, 3, 1, 0, 0, 0, 4'h0, 8'hA5};
      vecs[10] = '{8'hBB, 8'h00, 8'h00, 2, 0, 1, 0, 1, 4'h0, 8'hA5};
      vecs[11] = '{8'hBB, 8'h80, 8'h00, 2, 0, 0, 1, 0, 4'h0, 8'h00};
      for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;

      RST = 1'b0; RX_D_VLD = 1'b0; RX_P_DATA = 8'h00; TX_Busy = 1'b0;
      repeat (3) @(negedge CLK);
      chk("rst_outputs", {WR_En, RD_EN, Address, WrData, TX_P_DATA, TX_D_VLD, Frame_Err}, 0);
      chk("rst_busy", Ctrl_Busy, 0);
      RST = 1'b1;
      @(negedge CLK);

      for (int i = 0; i < 12; i++) begin
         snap();
         send_byte(vecs[i].b0, 10);
         if (vecs[i].nb > 1) send_byte(vecs[i].b1, 10);
         if (vecs[i].nb > 2) send_byte(vecs[i].b2, 0);
         repeat (8) @(negedge CLK);
         predict(vecs[i].b0, vecs[i].b1, vecs[i].b2, vecs[i].nb, ew, er, ee, et, ev);
         check_frame($sformatf("vec%0d", i), vecs[i].e_wr, vecs[i].e_rd, vecs[i].e_err,
                     vecs[i].e_tx, vecs[i].e_addr, vecs[i].e_val);
      end

      // Reset mid-frame discards the partial frame; the data byte that follows is ignored.
      snap();
      send_byte(8'hAA, 2);
      send_byte(8'h02, 2);
      chk("pre_rst_busy", Ctrl_Busy, 1);
      RST = 1'b0;
      #1;
      chk("midrst_outputs", {WR_En, RD_EN, Address, WrData, TX_P_DATA, TX_D_VLD, Frame_Err}, 0);
      chk("midrst_busy", Ctrl_Busy, 0);
      repeat (2) @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      send_byte(8'h5C, 10);
      check_frame("after_rst", 0, 0, 0, 0, 4'h0, 8'h00);
      chk("after_rst_busy", Ctrl_Busy, 0);

      // TX back-pressure, with a byte arriving during SEND that must be dropped.
      TX_Busy = 1'b1;
      snap();
      send_byte(8'hBB, 0);
      send_byte(8'h03, 5);
      hold = TX_P_DATA;
      chk("bp_data", hold, ref_mem[3]);
      changes = 0; pulses = 0;
      for (int k = 0; k < 45; k++) begin
         if (k == 10) send_byte(8'hAA, 0);
         else @(negedge CLK);
         if (TX_P_DATA != hold) changes++;
         if (TX_D_VLD) pulses++;
      end
      chk("bp_stable", changes, 0);
      chk("bp_no_tx", pulses, 0);
      chk("bp_busy", Ctrl_Busy, 1);
      TX_Busy = 1'b0;
      @(negedge CLK);
      chk("bp_tx_pulse", TX_D_VLD, 1);
      chk("bp_tx_data", TX_P_DATA, ref_mem[3]);
      @(negedge CLK);
      chk("bp_tx_single", TX_D_VLD, 0);
      chk("bp_idle", Ctrl_Busy, 0);
      check_frame("bp", 0, 1, 0, 1, 4'h3, ref_mem[3]);

      // Timeout: AA then silence.
      snap();
      send_byte(8'hAA, 0);
      seen = -1;
      for (int k = 1; k <= 1100; k++) begin
         @(negedge CLK);
         if (Frame_Err) begin seen = k; break; end
      end
      chk("timeout_latency", seen, 1023);
      chk("timeout_idle", Ctrl_Busy, 0);
      repeat (4) @(negedge CLK);
      check_frame("timeout", 0, 0, 1, 0, 4'h0, 8'h00);
      snap();
      send_byte(8'hBB, 3);
      send_byte(8'h00, 8);
      check_frame("post_timeout_rd", 0, 1, 0, 1, 4'h0, ref_mem[0]);

      // Random frames against the frame-level model.
      begin
         int n_to = 0;
         for (int f = 0; f < 40; f++) begin
            logic [7:0] op, a, d;
            int r, full, nb;
            r = $urandom_range(0, 9);
            if (r < 4) op = 8'hAA;
            else if (r < 8) op = 8'hBB;
            else begin
               op = 8'($urandom);
               if (op == 8'hAA || op == 8'hBB) op = op ^ 8'h01;
            end
            a = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 15)) : 8'($urandom);
            d = 8'($urandom);
            full = (op == 8'hAA) ? 3 : (op == 8'hBB) ? 2 : 1;
            nb = full;
            if (full > 1 && n_to < 3 && $urandom_range(0, 9) == 0) begin
               nb = $urandom_range(1, full - 1);
               n_to++;
            end
            snap();
            send_byte(op, (nb > 1) ? $urandom_range(0, 20) : 0);
            if (nb > 1) send_byte(a, (nb > 2) ? $urandom_range(0, 20) : 0);
            if (nb > 2) send_byte(d, 0);
            repeat ((nb < full) ? 1040 : 8) @(negedge CLK);
            predict(op, a, d, nb, ew, er, ee, et, ev);
            check_frame($sformatf("rnd%0d", f), ew, er, ee, et, a[3:0], ev);
         end
      end

      chk("strobe_exclusive", n_both, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/reg_cmd_ctrl.md
Name: reg_cmd_ctrl

Overview:
- Command front-end that sits between the UART receiver/transmitter pair and the register file.
- Parses byte frames from UART RX into register-file write and read transactions.
- Returns read data to UART TX with a single-byte handshake.
- Enforces an inter-byte frame timeout and flags malformed frames.

Parameters:
- DATA_WIDTH, 8, width of UART bytes and register data.
- ADDR_WIDTH, 4, register-file address width; the address byte must have bits [DATA_WIDTH-1:ADDR_WIDTH] equal to zero.
- WR_CMD, 8'hAA, opcode of a write frame: WR_CMD, addr, data.
- RD_CMD, 8'hBB, opcode of a read frame: RD_CMD, addr.
- TIMEOUT, 1023, maximum idle cycles allowed between bytes of one frame; counter width is clog2(TIMEOUT+1).

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous, active-low reset.
- RX_P_DATA  in  DATA_WIDTH  received byte; valid only while RX_D_VLD=1.
- RX_D_VLD  in  1  one-cycle strobe per received byte.
- WR_En  out  1  register-file write strobe.
- RD_EN  out  1  register-file read strobe.
- Address  out  ADDR_WIDTH  register-file address.
- WrData  out  DATA_WIDTH  register-file write data.
- RdData  in  DATA_WIDTH  register-file read data.
- RdData_Vaild  in  1  register-file read-data valid.
- TX_P_DATA  out  DATA_WIDTH  byte to transmit.
- TX_D_VLD  out  1  transmit request strobe.
- TX_Busy  in  1  transmitter busy.
- Frame_Err  out  1  one-cycle pulse on a bad address or a timeout.
- Ctrl_Busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset: all outputs 0; state=IDLE; timeout counter=0; latched address, data and read byte = 0. Reset is asynchronous and takes effect mid-frame; any partial frame is discarded.
- All outputs are registered.
- States:
  - IDLE: on RX_D_VLD with byte==WR_CMD -> WR_ADDR; byte==RD_CMD -> RD_ADDR; any other byte is ignored silently (no error).
  - WR_ADDR: on RX_D_VLD, latch byte -> WR_DATA.
  - WR_DATA: on RX_D_VLD, latch byte. If the address is legal -> WRITE, else pulse Frame_Err and -> IDLE.
  - WRITE: WR_En=1 for exactly one cycle with Address/WrData stable -> IDLE.
  - RD_ADDR: on RX_D_VLD, if the address is legal -> READ, else pulse Frame_Err and -> IDLE.
  - READ: RD_EN=1 for exactly one cycle with Address stable -> RD_WAIT.
  - RD_WAIT: on RdData_Vaild=1, latch RdData into TX_P_DATA -> SEND. The register file returns valid one cycle after RD_EN.
  - SEND: when TX_Busy=0, TX_D_VLD=1 for exactly one cycle -> IDLE. While TX_Busy=1, hold with TX_P_DATA stable.
- Strobe exclusivity: WR_En and RD_EN are never high together; each is high for at most one cycle per frame.
- Address/WrData hold their last values after use; they do not return to 0.
- Timeout:
  - Counter clears on entering WR_ADDR, WR_DATA or RD_ADDR, and on every RX_D_VLD.
  - It increments each cycle spent in those three states.
  - When it reaches TIMEOUT: pulse Frame_Err, go to IDLE, clear the counter.
  - RD_WAIT and SEND are not subject to the timeout.
- Bytes arriving during WRITE, READ, RD_WAIT or SEND are dropped; they are not queued.
- Address-legality check: bits [DATA_WIDTH-1:ADDR_WIDTH] of the address byte must all be 0.
- Ctrl_Busy = (state != IDLE).

Test Plan:
- Write frame: AA, 03, 5C (RX_D_VLD one cycle each, gaps of 10 cycles) -> one cycle after the 5C strobe, WR_En=1 for one cycle with Address=3, WrData=8'h5C; RD_EN stays 0; Frame_Err stays 0.
- Read frame: BB, 03 with the register-file model holding 8'h5C -> RD_EN pulses one cycle after the 03 strobe; RdData_Vaild follows one cycle later; with TX_Busy=0, TX_D_VLD pulses once with TX_P_DATA=8'h5C.
- TX back-pressure: same read with TX_Busy held 1 for 50 cycles -> TX_D_VLD stays 0 and TX_P_DATA is stable; TX_D_VLD pulses exactly once in the cycle after TX_Busy falls.
- Illegal address: AA, 13, 77 -> after the 77 strobe, Frame_Err pulses once and WR_En never asserts. BB, F0 -> Frame_Err pulses and RD_EN never asserts.
- Timeout: AA then silence, TIMEOUT=1023 -> Frame_Err pulses 1023 cycles after the AA strobe and the block returns to IDLE. A subsequent BB, 00 read completes normally.
- Reset and junk: RST low for 2 cycles mid-frame after AA, 02 -> all outputs 0 and Ctrl_Busy=0; a following 5C byte is ignored (no write). Unknown opcode 12 in IDLE -> no strobes and no Frame_Err.
